// File: rtl/f32_add_arbiter.sv
// Round-robin front end sharing one 2-cycle pipelined f32 adder among NUM_REQ requesters.
// Define F32_ADD_ARB_FIXED_PRIO_EN to build lowest-index-wins fixed priority instead.

module f32_add_core (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] big_s, sml_s, spec_val_s;
    logic [7:0]  eb_s, es_s, d_s;
    logic [26:0] mb_s, msm_s, al_s;
    logic [53:0] shf_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, nan_s;

    logic        s1_sign_r, s1_sub_r, s1_spec_r;
    logic [7:0]  s1_exp_r;
    logic [26:0] s1_mb_r, s1_ms_r;
    logic [31:0] s1_spec_val_r;

    logic [27:0] sum_s;
    logic [26:0] norm_s;
    logic [4:0]  lz_s;
    logic [7:0]  sh_s;
    logic [8:0]  ne_s, fe_s;
    logic [24:0] mant_s;
    logic        rnd_up_s;
    logic [31:0] res_s;

    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       done;
        n    = 5'd0;
        done = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!done && !v[i]) begin
                n = n + 5'd1;
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

    // Stage 1: special-case detection, magnitude swap, alignment with sticky collapse.
    always_comb begin
        a_nan_s    = (&a[30:23]) & (|a[22:0]);
        b_nan_s    = (&b[30:23]) & (|b[22:0]);
        a_inf_s    = (&a[30:23]) & ~(|a[22:0]);
        b_inf_s    = (&b[30:23]) & ~(|b[22:0]);
        nan_s      = a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (a[31] ^ b[31]));
        spec_val_s = nan_s ? 32'h7FC0_0000 : (a_inf_s ? a : b);
        big_s      = (b[30:0] > a[30:0]) ? b : a;
        sml_s      = (b[30:0] > a[30:0]) ? a : b;
        eb_s       = (big_s[30:23] == 8'd0) ? 8'd1 : big_s[30:23];
        es_s       = (sml_s[30:23] == 8'd0) ? 8'd1 : sml_s[30:23];
        mb_s       = {big_s[30:23] != 8'd0, big_s[22:0], 3'b000};
        msm_s      = {sml_s[30:23] != 8'd0, sml_s[22:0], 3'b000};
        d_s        = eb_s - es_s;
        shf_s      = {msm_s, 27'd0} >> d_s;
        if (d_s > 8'd26) begin
            al_s = {26'd0, |msm_s};
        end else begin
            al_s = shf_s[53:27] | {26'd0, |shf_s[26:0]};
        end
    end

    // Stage 1 pipeline register (core datapath carries no reset).
    always_ff @(posedge clk) begin
        s1_sign_r     <= big_s[31];
        s1_sub_r      <= big_s[31] ^ sml_s[31];
        s1_spec_r     <= nan_s | a_inf_s | b_inf_s;
        s1_spec_val_r <= spec_val_s;
        s1_exp_r      <= eb_s;
        s1_mb_r       <= mb_s;
        s1_ms_r       <= al_s;
    end

    // Stage 2: add/subtract, normalise (denormal-limited), round to nearest even, pack.
    always_comb begin
        sum_s = s1_sub_r ? ({1'b0, s1_mb_r} - {1'b0, s1_ms_r}) : ({1'b0, s1_mb_r} + {1'b0, s1_ms_r});
        lz_s  = clz27(sum_s[26:0]);
        sh_s  = 8'd0;
        if (sum_s[27]) begin
            norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
            ne_s   = {1'b0, s1_exp_r} + 9'd1;
        end else begin
            sh_s   = ({3'd0, lz_s} < s1_exp_r) ? {3'd0, lz_s} : (s1_exp_r - 8'd1);
            norm_s = sum_s[26:0] << sh_s;
            ne_s   = {1'b0, s1_exp_r} - {1'b0, sh_s};
        end
        rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s   = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
        fe_s     = mant_s[24] ? (ne_s + 9'd1) : (mant_s[23] ? ne_s : 9'd0);
        if (s1_spec_r) begin
            res_s = s1_spec_val_r;
        end else if (sum_s == 28'd0) begin
            res_s = {s1_sub_r ? 1'b0 : s1_sign_r, 31'd0};
        end else if (fe_s >= 9'd255) begin
            res_s = {s1_sign_r, 8'hFF, 23'd0};
        end else begin
            res_s = {s1_sign_r, fe_s[7:0], mant_s[22:0]};
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk) begin
        y <= res_s;
    end
endmodule

module f32_add_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CORE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [NUM_REQ*32-1:0] resp_data,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    eligible_s, req_ready_s, inflight_r, resp_valid_r;
    logic [NUM_REQ*32-1:0] resp_data_r;
    logic                  grant_any_s, hit_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic [31:0]           core_a_s, core_b_s, core_y_s;
    logic [CORE_LAT-1:0]   tag_vld_r;
    logic [IDX_W-1:0]      tag_idx_r [CORE_LAT];
    logic                  fill_s;
    logic [IDX_W-1:0]      fill_idx_s;
    int                    j_s;

    // rst_n gating keeps req_ready low while reset is asserted.
    assign eligible_s = req_valid & ~inflight_r & ~resp_valid_r & {NUM_REQ{rst_n}};

`ifdef F32_ADD_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest eligible index is the final winner.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        hit_s       = 1'b0;
        j_s         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j_s         = k;
            hit_s       = eligible_s[j_s];
            grant_any_s = grant_any_s | hit_s;
            grant_idx_s = hit_s ? IDX_W'(j_s) : grant_idx_s;
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_r;

    // Round robin: scan offsets downward from rr_ptr so the nearest eligible index wins.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        hit_s       = 1'b0;
        j_s         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j_s         = int'(rr_ptr_r) + k;
            j_s         = (j_s >= NUM_REQ) ? (j_s - NUM_REQ) : j_s;
            hit_s       = eligible_s[j_s];
            grant_any_s = grant_any_s | hit_s;
            grant_idx_s = hit_s ? IDX_W'(j_s) : grant_idx_s;
        end
    end

    // Pointer advances past the winner; held on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (grant_any_s) begin
            rr_ptr_r <= (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (grant_idx_s + {{(IDX_W-1){1'b0}}, 1'b1});
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // One-hot grant and core operand steering; an idle core sees zeros.
    always_comb begin
        req_ready_s              = {NUM_REQ{1'b0}};
        req_ready_s[grant_idx_s] = grant_any_s;
        core_a_s                 = grant_any_s ? req_a[{grant_idx_s, 5'd0} +: 32] : 32'h0000_0000;
        core_b_s                 = grant_any_s ? req_b[{grant_idx_s, 5'd0} +: 32] : 32'h0000_0000;
    end

    f32_add_core u_core (
        .clk (clk),
        .a   (core_a_s),
        .b   (core_b_s),
        .y   (core_y_s)
    );

    // Tag pipeline mirrors the core latency; its valids alone qualify the core output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= {CORE_LAT{1'b0}};
            for (int s = 0; s < CORE_LAT; s++) tag_idx_r[s] <= {IDX_W{1'b0}};
        end else begin
            tag_vld_r[0] <= grant_any_s;
            tag_idx_r[0] <= grant_idx_s;
            for (int s = 1; s < CORE_LAT; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_idx_r[s] <= tag_idx_r[s-1];
            end
        end
    end

    assign fill_s     = tag_vld_r[CORE_LAT-1];
    assign fill_idx_s = tag_idx_r[CORE_LAT-1];

    // Per-requester slot and in-flight tracking; a slot is always empty when its result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r   <= {NUM_REQ{1'b0}};
            resp_valid_r <= {NUM_REQ{1'b0}};
            resp_data_r  <= {(NUM_REQ*32){1'b0}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fill_s && (fill_idx_s == IDX_W'(i))) begin
                    resp_data_r[i*32 +: 32] <= core_y_s;
                    resp_valid_r[i]         <= 1'b1;
                    inflight_r[i]           <= 1'b0;
                end else begin
                    if (resp_valid_r[i] && resp_ready[i]) begin
                        resp_valid_r[i] <= 1'b0;
                    end else begin
                        resp_valid_r[i] <= resp_valid_r[i];
                    end
                    inflight_r[i] <= inflight_r[i] | req_ready_s[i];
                end
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign busy       = |(inflight_r | resp_valid_r);
endmodule

// File: tb/tb_f32_add_arbiter.sv
// Directed bench for f32_add_arbiter: expected results queue per requester, drained by a monitor.
module tb_f32_add_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*32-1:0] req_a, req_b, resp_data;
    logic           busy;
    int             checks = 0;
    int             errors = 0;
    logic [31:0]    exp_q [N][$];
    logic [31:0]    t3_b   [N];
    logic [31:0]    t3_exp [N];

    always #5 clk = ~clk;

    f32_add_arbiter #(.NUM_REQ(N), .CORE_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted response is compared against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp%0d actual %h required none", i, resp_data[i*32 +: 32]);
                    end else begin
                        check($sformatf("resp_data%0d", i), resp_data[i*32 +: 32], exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        logic got;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
        exp_q[i].push_back(e);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ready[i];
            tick();
        end
        req_valid[i] = 1'b0;
        check($sformatf("grant_seen%0d", i), {31'd0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            @(negedge clk);
            idle = ~busy;
        end
        check("drain", {31'd0, idle}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;
        t3_b   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        t3_exp = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

        // Reset state
        #1;
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single op latency: 1.0 + 2.0 = 3.0
        req_valid[0]   = 1'b1;
        req_a[31:0]    = 32'h3F80_0000;
        req_b[31:0]    = 32'h4000_0000;
        exp_q[0].push_back(32'h4040_0000);
        @(negedge clk);
        check("t1_ready_c0", {28'd0, req_ready}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_valid_c1", {28'd0, resp_valid}, 32'd0);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        check("t1_valid_c2", {28'd0, resp_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t1_valid_c3", {28'd0, resp_valid}, 32'd1);
        tick();
        @(negedge clk);
        check("t1_valid_c4", {28'd0, resp_valid}, 32'd0);
        check("t1_busy_c4", {31'd0, busy}, 32'd0);
        tick();

        // Arithmetic vectors: cancellation, inf-inf, ties-to-even, normalising subtract
        issue(0, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
        issue(1, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        issue(1, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        issue(2, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
        issue(3, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        wait_idle();

        // All four saturated: grants 0,1,2,3,... back to back
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = 32'h3F80_0000;
            req_b[i*32 +: 32] = t3_b[i];
        end
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("t3_grant_c%0d", c), {28'd0, req_ready}, 32'd1 << (c % N));
            exp_q[c % N].push_back(t3_exp[c % N]);
            tick();
        end
        req_valid = '0;
        wait_idle();

        // Parked slot on requester 1 while requester 0 keeps being served
        resp_ready[1] = 1'b0;
        issue(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        for (int c = 0; c < 10 && !resp_valid[1]; c++) begin
            @(negedge clk);
            if (!resp_valid[1]) tick();
        end
        tick();
        req_valid[1]      = 1'b1;
        req_a[63:32]      = 32'h3F80_0000;
        req_a[31:0]       = 32'h3F80_0000;
        req_b[31:0]       = 32'h3F80_0000;
        req_valid[0]      = 1'b1;
        g0 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t4_ready1_low", {31'd0, req_ready[1]}, 32'd0);
            check("t4_valid1", {31'd0, resp_valid[1]}, 32'd1);
            check("t4_data1_stable", resp_data[63:32], 32'h4080_0000);
            if (req_ready[0]) begin
                exp_q[0].push_back(32'h4000_0000);
                g0++;
            end
            tick();
        end
        req_valid     = '0;
        resp_ready[1] = 1'b1;
        check("t4_served0", g0, 32'd3);
        wait_idle();

        // Reset pulse with two ops in flight
        req_a[95:64]  = 32'h3F80_0000;
        req_b[95:64]  = 32'h3F80_0000;
        req_a[127:96] = 32'h4000_0000;
        req_b[127:96] = 32'h4000_0000;
        req_valid     = 4'b1100;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", {28'd0, req_ready}, 32'd0);
        check("t5_rst_valid", {28'd0, resp_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_data0", resp_data[31:0], 32'd0);
        check("t5_rst_data1", resp_data[63:32], 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_first_grant", {28'd0, req_ready}, 32'd4);
        check("t5_valid_r0", {28'd0, resp_valid}, 32'd0);
        exp_q[2].push_back(32'h4000_0000);
        tick();
        @(negedge clk);
        check("t5_second_grant", {28'd0, req_ready}, 32'd8);
        check("t5_valid_r1", {28'd0, resp_valid}, 32'd0);
        exp_q[3].push_back(32'h4080_0000);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t5_valid_r2", {28'd0, resp_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t5_valid_r3", {28'd0, resp_valid}, 32'd4);
        wait_idle();

        // Idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_idle_busy", {31'd0, busy}, 32'd0);
            check("t6_idle_ready", {28'd0, req_ready}, 32'd0);
            tick();
        end

        for (int i = 0; i < N; i++) begin
            check($sformatf("queue_empty%0d", i), exp_q[i].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/f32_add_arbiter.md
# f32_add_arbiter

Shares one two-stage pipelined f32 adder core among `NUM_REQ` independent requesters. The core accepts new inputs every cycle, has no stall and no reset, and produces its result exactly 2 cycles after its inputs. This block does four things:
- arbitrates requests with a valid/ready handshake;
- issues at most one operation per cycle into the core;
- tracks in-flight operations with a reset-cleared tag pipeline;
- steers each result into a per-requester one-deep response slot drained by its own valid/ready handshake.

It is the scheduling front end for every shared f32 add in the checksum/accumulation datapath.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CORE_LAT`, default 2: adder core latency in cycles. Must equal the instantiated core's latency.

Ports:
- `clk`, in, 1: the only clock; all state is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester operation request.
- `req_ready`, out, `NUM_REQ`: per-requester grant; at most one bit is high per cycle.
- `req_a`, in, `NUM_REQ*32`: operand A, requester i at bits [32i+31:32i].
- `req_b`, in, `NUM_REQ*32`: operand B, same packing as `req_a`.
- `resp_valid`, out, `NUM_REQ`: response slot i holds a result.
- `resp_ready`, in, `NUM_REQ`: requester i consumes its slot.
- `resp_data`, out, `NUM_REQ*32`: slot contents, same packing as `req_a`.
- `busy`, out, 1: high while any operation is in flight or any slot is full.

## Operation
- A handshake occurs when `req_valid[i] & req_ready[i]`.
- `eligible[i] = req_valid[i] & ~inflight[i] & ~resp_valid[i]`.
- `req_ready` is combinational from `eligible` and the arbitration pointer.
- `req_ready[i]` may depend on `req_valid[i]`. Requesters must not make `req_valid` depend on `req_ready`.
- Each requester has at most one operation in flight or parked in its slot. This guarantees a slot is never written while it is full.
- Arbitration is round-robin: the grant goes to the first eligible index at or after `rr_ptr`, searching upward with wrap. After a grant to i, `rr_ptr` becomes `(i+1) mod NUM_REQ`. `rr_ptr` is unchanged on cycles with no grant.
- Core inputs:
  - With a grant, the core receives the granted requester's `req_a`/`req_b`.
  - With no grant, the core receives 32'h0 on both inputs. Its output is then ignored.
- Tag pipeline:
  - `CORE_LAT` stages of {valid, idx[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {grant_any, grant_idx}.
  - When the last stage is valid, the core output is written into `slot[idx]`, `resp_valid[idx]` is set and `inflight[idx]` is cleared.
- `inflight[i]` is set on the handshake edge.
- `resp_valid[i]` is cleared on the edge where `resp_valid[i] & resp_ready[i]`.
- A slot fill and a pop of a different requester in the same cycle are independent.
- A fill and a pop of the same slot in the same cycle cannot occur, because the slot must be empty at issue.
- The block performs no arithmetic of its own. Result values, including NaN canonicalisation (0x7FC00000), come from the core.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, `rr_ptr`=0, all tag valids=0, `inflight`=0.
- The core has no reset. The tag valids alone qualify its output.
- Reset asserted mid-operation discards all in-flight and parked results. The first grant after reset release goes to the lowest eligible index.
- Latency: a handshake in cycle k gives `resp_valid` high in cycle k+`CORE_LAT`+1, i.e. k+3 by default.
- Single-requester throughput:
  - Handshake at k, result at k+3, pop in cycle k+3, next handshake at k+4.
  - One operation every 4 cycles.
- Aggregate throughput: one operation per cycle when at least `CORE_LAT`+2 requesters are saturated and popping immediately.
- `busy` is registered-state-derived: OR of `inflight` and `resp_valid`.

## Configuration
- `F32_ADD_ARB_FIXED_PRIO_EN`:
  - When defined, arbitration is fixed priority: the lowest eligible index wins and `rr_ptr` is not implemented.
  - When undefined, arbitration is round-robin as specified above.
  - Latency, slot and tag behaviour are identical in both builds.

## Test plan
- Req 0: A=0x3F800000, B=0x40000000 in cycle 0 with `resp_ready[0]`=1. Required: `req_ready[0]`=1 in cycle 0, `resp_valid[0]`=1 with `resp_data`=0x40400000 in cycle 3, slot empty in cycle 4.
- Req 2: 0x3FC00000 + 0xBFC00000. Required: 0x00000000. Req 3: 0x7F800000 + 0xFF800000. Required: 0x7FC00000.
- All 4 requesters valid continuously with `resp_ready`=all 1s. Round-robin build: grants 0,1,2,3,0,1,… one per cycle with no bubbles. Fixed-priority build: grants 0,1,2,3,0,… (0 is re-eligible at cycle 4).
- Req 1 result parked with `resp_ready[1]`=0 for 10 cycles. Required: `req_ready[1]`=0 throughout, other requesters still served, `resp_data[1]` stable.
- `rst_n` pulsed low for 1 cycle while 2 operations are in flight. Required: all outputs 0 immediately (asynchronous), no `resp_valid` for those operations afterwards, next grant to the lowest eligible index.
- Idle for 5 cycles. Required: `busy`=0 and `req_ready`=0.
